// File: rtl/aes_host_pkg.sv
// Shared constants, mode encodings and FSM state type for the AES host controller.
package aes_host_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        KEY_PULSE,
        KEY_SKIP,
        KEY_WAIT,
        READY,
        BLK_PULSE,
        BLK_SKIP,
        BLK_WAIT,
        OUT_HOLD
    } state_t;

endpackage

// File: rtl/aes_host_wdog.sv
// Wait-state watchdog for aes_host_ctrl; only built when AES_HOST_CTRL_TIMEOUT_EN is defined.
`ifdef AES_HOST_CTRL_TIMEOUT_EN
module aes_host_wdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // Fires during the LIMIT-th consecutive wait cycle.
    assign expire = en && (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/aes_host_ctrl.sv
// Sequencer between a host request stream and aes_core: start pulses, operand hold, result stream.
// Optional watchdog with sticky err output when AES_HOST_CTRL_TIMEOUT_EN is defined.
module aes_host_ctrl #(
    parameter int BLOCK_W        = aes_host_pkg::BLOCK_W,
    parameter int KEY_W          = aes_host_pkg::KEY_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic               blk_mode,
    input  logic [BLOCK_W-1:0] blk_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [BLOCK_W-1:0] res_data,
    output logic               res_mode,
    output logic               key_loaded,
    output logic               busy,
    output logic               core_reset_key,
    output logic               core_reset_enc,
    output logic               core_reset_dec,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_block_enc,
    output logic [BLOCK_W-1:0] core_block_dec,
    input  logic               core_ready_key,
    input  logic               core_iready_enc,
    input  logic               core_iready_dec,
    input  logic               core_oready_enc,
    input  logic               core_oready_dec,
    input  logic [BLOCK_W-1:0] core_result_enc,
    input  logic [BLOCK_W-1:0] core_result_dec
`ifdef AES_HOST_CTRL_TIMEOUT_EN
    ,
    output logic               err
`endif
);
    import aes_host_pkg::*;

    state_t state, state_nxt;
    logic   mode_q;
    logic   sel_iready, sel_oready;
    logic   key_acc, blk_acc, res_cap, wait_exp;

    assign sel_iready = (blk_mode == MODE_DEC) ? core_iready_dec : core_iready_enc;
    assign sel_oready = (mode_q == MODE_DEC) ? core_oready_dec : core_oready_enc;

    // Requests are refused while reset is held so every output reads 0 in reset.
    assign key_ready = reset_n && ((state == IDLE) || (state == READY));
    assign blk_ready = (state == READY) && !key_valid && sel_iready;
    assign key_acc   = key_valid && key_ready;
    assign blk_acc   = blk_valid && blk_ready;
    assign res_cap   = (state == BLK_WAIT) && sel_oready;

    assign res_valid      = (state == OUT_HOLD);
    assign res_mode       = mode_q;
    assign busy           = (state != IDLE) && (state != READY);
    assign core_reset_key = (state == KEY_PULSE);
    assign core_reset_enc = (state == BLK_PULSE) && (mode_q == MODE_ENC);
    assign core_reset_dec = (state == BLK_PULSE) && (mode_q == MODE_DEC);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (key_acc) state_nxt = KEY_PULSE;
            KEY_PULSE: state_nxt = KEY_SKIP;
            KEY_SKIP:  state_nxt = KEY_WAIT;
            KEY_WAIT: begin
                if (core_ready_key)  state_nxt = READY;
                else if (wait_exp)   state_nxt = IDLE;
            end
            READY: begin
                if (key_acc)         state_nxt = KEY_PULSE;
                else if (blk_acc)    state_nxt = BLK_PULSE;
            end
            BLK_PULSE: state_nxt = BLK_SKIP;
            BLK_SKIP:  state_nxt = BLK_WAIT;
            BLK_WAIT: begin
                if (sel_oready)      state_nxt = OUT_HOLD;
                else if (wait_exp)   state_nxt = IDLE;
            end
            OUT_HOLD:  if (res_ready) state_nxt = READY;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            key_loaded     <= 1'b0;
            core_key       <= '0;
            core_block_enc <= '0;
            core_block_dec <= '0;
            mode_q         <= MODE_ENC;
            res_data       <= '0;
        end else begin
            state <= state_nxt;
            if (key_acc) begin
                core_key   <= key_in;
                key_loaded <= 1'b0;
            end else if ((state == KEY_WAIT) && core_ready_key) begin
                key_loaded <= 1'b1;
            end else if (wait_exp) begin
                key_loaded <= 1'b0;
            end
            if (blk_acc) begin
                mode_q <= blk_mode;
                if (blk_mode == MODE_DEC) core_block_dec <= blk_in;
                else                      core_block_enc <= blk_in;
            end
            if (res_cap) begin
                res_data <= (mode_q == MODE_DEC) ? core_result_dec : core_result_enc;
            end
        end
    end

`ifdef AES_HOST_CTRL_TIMEOUT_EN
    logic wd_clr, wd_en;

    // Counter restarts in the skip cycle, so it counts wait cycles only.
    assign wd_clr = (state == KEY_SKIP) || (state == BLK_SKIP);
    assign wd_en  = ((state == KEY_WAIT) && !core_ready_key) ||
                    ((state == BLK_WAIT) && !sel_oready);

    aes_host_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wait_exp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err <= 1'b0;
        else if (wait_exp) err <= 1'b1;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wait_exp = 1'b0;
`endif

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Directed bench for aes_host_ctrl: the core is driven by hand, results go through a scoreboard queue.
// Also covers the watchdog when AES_HOST_CTRL_TIMEOUT_EN is defined.
module tb_aes_host_ctrl;

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct packed {
        logic         mode;
        logic [127:0] data;
    } exp_t;

    logic         clk, reset_n;
    logic         key_valid, key_ready, blk_valid, blk_ready, blk_mode;
    logic [127:0] key_in, blk_in, res_data, core_key, core_block_enc, core_block_dec;
    logic         res_valid, res_ready, res_mode, key_loaded, busy;
    logic         core_reset_key, core_reset_enc, core_reset_dec;
    logic         core_ready_key, core_iready_enc, core_iready_dec;
    logic         core_oready_enc, core_oready_dec;
    logic [127:0] core_result_enc, core_result_dec;
`ifdef AES_HOST_CTRL_TIMEOUT_EN
    logic         err;
`endif

    int   tests = 0;
    int   fails = 0;
    int   key_pulses = 0;
    int   enc_pulses = 0;
    int   dec_pulses = 0;
    int   results_seen = 0;
    exp_t exp_q[$];

    aes_host_ctrl #(.BLOCK_W(128), .KEY_W(128), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .key_in         (key_in),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .blk_mode       (blk_mode),
        .blk_in         (blk_in),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_mode       (res_mode),
        .key_loaded     (key_loaded),
        .busy           (busy),
        .core_reset_key (core_reset_key),
        .core_reset_enc (core_reset_enc),
        .core_reset_dec (core_reset_dec),
        .core_key       (core_key),
        .core_block_enc (core_block_enc),
        .core_block_dec (core_block_dec),
        .core_ready_key (core_ready_key),
        .core_iready_enc(core_iready_enc),
        .core_iready_dec(core_iready_dec),
        .core_oready_enc(core_oready_enc),
        .core_oready_dec(core_oready_dec),
        .core_result_enc(core_result_enc),
        .core_result_dec(core_result_dec)
`ifdef AES_HOST_CTRL_TIMEOUT_EN
        ,
        .err            (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a block request and records the result the scoreboard should see for it.
    task automatic applyStimulus(input logic mode, input logic [127:0] blk, input logic [127:0] expected);
        exp_q.push_back('{mode: mode, data: expected});
        blk_mode  = mode;
        blk_in    = blk;
        blk_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (core_reset_key) key_pulses++;
        if (core_reset_enc) enc_pulses++;
        if (core_reset_dec) dec_pulses++;
    end

    // Scoreboard monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            exp_t e;
            results_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", res_data, 128'h0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_res_data", res_data, e.data);
                checkOutput("sb_res_mode", res_mode, e.mode);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        key_valid = 0; key_in = '0; blk_valid = 0; blk_mode = 0; blk_in = '0; res_ready = 1;
        core_ready_key = 0; core_iready_enc = 0; core_iready_dec = 0;
        core_oready_enc = 0; core_oready_dec = 0; core_result_enc = '0; core_result_dec = '0;
        #12;
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_key_ready", key_ready, 0);
        checkOutput("rst_key_loaded", key_loaded, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_res_data", res_data, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Block request with no key loaded must stall in IDLE.
        core_iready_enc = 1;
        applyStimulus(1'b0, PT1, CT1);
        tick(); tick();
        checkOutput("blk_stall_idle", blk_ready, 0);
        checkOutput("idle_not_busy", busy, 0);
        checkOutput("idle_key_ready", key_ready, 1);
        key_in = KEY1; key_valid = 1;
        tick();
        key_valid = 0;
        checkOutput("key_pulse", core_reset_key, 1);
        checkOutput("core_key1", core_key, KEY1);
        checkOutput("blk_stall_keyload", blk_ready, 0);
        checkOutput("key_ready_busy", key_ready, 0);
        tick();
        checkOutput("key_pulse_one_cycle", core_reset_key, 0);
        tick();
        core_ready_key = 1;
        checkOutput("key_loaded_pending", key_loaded, 0);
        tick();
        checkOutput("key_loaded1", key_loaded, 1);
        checkOutput("key_pulse_count1", key_pulses, 1);
        checkOutput("blk_ready_enc", blk_ready, 1);
        tick();
        blk_valid = 0;
        checkOutput("enc_pulse", core_reset_enc, 1);
        checkOutput("enc_no_dec_pulse", core_reset_dec, 0);
        checkOutput("core_block_enc1", core_block_enc, PT1);
        tick(); tick();
        core_result_enc = CT1; core_oready_enc = 1;
        checkOutput("enc_no_early_res", res_valid, 0);
        tick();
        core_oready_enc = 0;
        checkOutput("enc_res_valid", res_valid, 1);
        tick();
        checkOutput("enc_res_cleared", res_valid, 0);
        checkOutput("enc_pulse_count", enc_pulses, 1);

        // Decrypt with wrong-mode oready noise and a 10-cycle output stall.
        res_ready = 0;
        core_iready_dec = 1;
        applyStimulus(1'b1, CT1, PT1);
        tick();
        blk_valid = 0;
        checkOutput("dec_pulse", core_reset_dec, 1);
        checkOutput("dec_no_enc_pulse", core_reset_enc, 0);
        checkOutput("core_block_dec", core_block_dec, CT1);
        checkOutput("core_block_enc_kept", core_block_enc, PT1);
        tick(); tick();
        core_oready_enc = 1; core_result_enc = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        tick();
        checkOutput("ignore_other_oready", res_valid, 0);
        core_oready_enc = 0; core_result_dec = PT1; core_oready_dec = 1;
        tick();
        core_oready_dec = 0; core_result_dec = '0;
        blk_mode = 1; blk_in = PT2; blk_valid = 1;
        #1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_res_valid", res_valid, 1);
            checkOutput("hold_res_data", res_data, PT1);
            checkOutput("hold_res_mode", res_mode, 1);
            checkOutput("hold_blk_ready", blk_ready, 0);
            tick();
        end
        blk_valid = 0; res_ready = 1;
        tick();
        checkOutput("dec_res_cleared", res_valid, 0);
        checkOutput("dec_pulse_count", dec_pulses, 1);

        // Key and block together in READY: key first; then a stale oready across pulse/skip.
        key_in = KEY2; key_valid = 1;
        core_iready_enc = 1;
        applyStimulus(1'b0, PT2, CT2);
        #1;
        checkOutput("key_wins_blk_ready", blk_ready, 0);
        checkOutput("key_wins_key_ready", key_ready, 1);
        tick();
        key_valid = 0;
        checkOutput("key2_loaded_cleared", key_loaded, 0);
        checkOutput("core_key2", core_key, KEY2);
        tick();
        checkOutput("stale_ready_key_ignored", key_loaded, 0);
        tick(); tick();
        checkOutput("key_loaded2", key_loaded, 1);
        checkOutput("key_pulse_count2", key_pulses, 2);
        core_oready_enc = 1; core_result_enc = CT1;
        #1;
        checkOutput("blk_after_key", blk_ready, 1);
        tick();
        blk_valid = 0;
        checkOutput("stale_pulse_no_res", res_valid, 0);
        tick();
        checkOutput("stale_skip_no_res", res_valid, 0);
        core_result_enc = CT2;
        tick();
        checkOutput("stale_wait_no_res", res_valid, 0);
        tick();
        checkOutput("stale_res_valid", res_valid, 1);
        core_oready_enc = 0;
        tick();

        // Asynchronous reset in the middle of a block wait.
        applyStimulus(1'b1, CT2, 128'h0);
        exp_q.pop_back();
        tick();
        blk_valid = 0;
        tick(); tick();
        checkOutput("wait_busy", busy, 1);
        #2;
        reset_n = 0;
        #1;
        checkOutput("arst_key_loaded", key_loaded, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_res_valid", res_valid, 0);
        checkOutput("arst_res_data", res_data, 0);
        checkOutput("arst_core_key", core_key, 0);
        checkOutput("arst_block_enc", core_block_enc, 0);
        checkOutput("arst_block_dec", core_block_dec, 0);
        checkOutput("arst_key_ready", key_ready, 0);
        tick(); tick();
        reset_n = 1;
        #1;
        checkOutput("post_rst_blk_ready", blk_ready, 0);

`ifdef AES_HOST_CTRL_TIMEOUT_EN
        key_in = KEY1; key_valid = 1;
        tick();
        key_valid = 0;
        tick(); tick(); tick();
        checkOutput("to_key_loaded", key_loaded, 1);
        blk_mode = 0; blk_in = PT1; blk_valid = 1;
        tick();
        blk_valid = 0;
        tick(); tick();
        repeat (15) tick();
        checkOutput("to_still_busy", busy, 1);
        checkOutput("to_no_err_yet", err, 0);
        tick();
        checkOutput("to_idle", busy, 0);
        checkOutput("to_err", err, 1);
        checkOutput("to_no_result", res_valid, 0);
        checkOutput("to_key_cleared", key_loaded, 0);
        tick();
        checkOutput("to_err_sticky", err, 1);
`endif

        tick();
        checkOutput("results_seen", results_seen, 3);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
